prog_loader: RTL and testbench

Boot-time program loader upstream of instruction memory in `computer`. Receives a program image over a UART RX line (8N1) and writes it byte-by-byte into instruction memory through a write port. Holds the CPU in reset until the image is complete, then releases it. Running with an empty or partial image is impossible by construction.

---
 rtl/loader_pkg.sv | 30 +++
 rtl/uart_rx.sv | 112 +++++++++++
 rtl/prog_loader.sv | 116 +++++++++++
 tb/tb_prog_loader.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and constants for the boot program loader
// Contents:
//   load_state_e         loader FSM states
//   rx_state_e           UART receiver states
//   DEFAULT_CLKS_PER_BIT 100 MHz / 115200 baud
//   len_from_byte()      maps the length byte to a 9-bit image length
package loader_pkg;

  typedef enum logic [1:0] {
    WAIT_LEN,
    LOAD,
    DONE,
    ERROR
  } load_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  localparam int DEFAULT_CLKS_PER_BIT = 868;

  // A length byte of zero stands for a full 256-byte image.
  function automatic logic [8:0] len_from_byte(input logic [7:0] b);
    return (b == 8'd0) ? 9'd256 : {1'b0, b};
  endfunction

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and framing check
// Ports:
//   clock     in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   rx        in   asynchronous serial line, idle high
//   rx_data   out  received byte, valid while rx_valid is high
//   rx_valid  out  one-cycle pulse per good frame
//   rx_ferr   out  one-cycle pulse per frame with a low stop bit
module uart_rx
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_ferr
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;

  logic          sync1_q;
  logic          sync2_q;
  logic          prev_q;
  rx_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          ferr_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          cnt_q <= '0;
          // Only a high-to-low transition arms a frame, so after a break
          // the line must return high before the next start is accepted.
          if (prev_q && !sync2_q) begin
            state_q <= RX_START;
          end
        end
        RX_START: begin
          if (cnt_q == CW'(HALF - 1)) begin
            cnt_q <= '0;
            if (sync2_q) begin
              state_q <= RX_IDLE;  // glitch, not a real start bit
            end else begin
              bit_q   <= 3'd0;
              state_q <= RX_DATA;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
            cnt_q   <= '0;
            shift_q <= {sync2_q, shift_q[7:1]};  // LSB arrives first
            if (bit_q == 3'd7) begin
              state_q <= RX_STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
            cnt_q   <= '0;
            state_q <= RX_IDLE;
            if (sync2_q) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
            end else begin
              ferr_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign rx_data  = data_q;
  assign rx_valid = valid_q;
  assign rx_ferr  = ferr_q;

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - loads a length-prefixed UART image into instruction memory
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   rx           in   UART serial input, idle high
//   imem_w_en    out  instruction memory write strobe, one cycle per byte
//   imem_addr    out  write address, holds when strobe is low
//   imem_w_data  out  write data, holds when strobe is low
//   cpu_reset    out  CPU hold, released only once the image is complete
//   done         out  image fully loaded
//   error        out  sticky framing error
module prog_loader
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic       imem_w_en,
  output logic [7:0] imem_addr,
  output logic [7:0] imem_w_data,
  output logic       cpu_reset,
  output logic       done,
  output logic       error
);

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ferr;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_rx (
    .clock   (clock),
    .reset   (reset),
    .rx      (rx),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_ferr (rx_ferr)
  );

  load_state_e state_q;
  logic [8:0]  len_q;
  logic [8:0]  count_q;
  logic [8:0]  count_d;
  logic        w_en_q;
  logic [7:0]  addr_q;
  logic [7:0]  wdata_q;
  logic        cpu_reset_q;
  logic        done_q;
  logic        error_q;

  assign count_d = count_q + 9'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= WAIT_LEN;
      len_q       <= 9'd0;
      count_q     <= 9'd0;
      w_en_q      <= 1'b0;
      addr_q      <= 8'd0;
      wdata_q     <= 8'd0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      w_en_q <= 1'b0;
      case (state_q)
        WAIT_LEN: begin
          if (rx_ferr) begin
            error_q <= 1'b1;
            state_q <= ERROR;
          end else if (rx_valid) begin
            len_q   <= len_from_byte(rx_data);
            count_q <= 9'd0;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (rx_ferr) begin
            error_q <= 1'b1;
            state_q <= ERROR;
          end else if (rx_valid) begin
            w_en_q  <= 1'b1;
            addr_q  <= count_q[7:0];
            wdata_q <= rx_data;
            count_q <= count_d;
            if (count_d == len_q) begin
              state_q <= DONE;
            end
          end
        end
        // done/cpu_reset change one cycle after the last strobe so the
        // CPU's first fetch sees the final write.
        DONE: begin
          done_q      <= 1'b1;
          cpu_reset_q <= 1'b0;
        end
        ERROR: begin
          error_q     <= 1'b1;
          cpu_reset_q <= 1'b1;
        end
        default: state_q <= WAIT_LEN;
      endcase
    end
  end

  assign imem_w_en   = w_en_q;
  assign imem_addr   = addr_q;
  assign imem_w_data = wdata_q;
  assign cpu_reset   = cpu_reset_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - self-checking bench for prog_loader
module tb_prog_loader;

  localparam int CPB = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       imem_w_en;
  logic [7:0] imem_addr;
  logic [7:0] imem_w_data;
  logic       cpu_reset;
  logic       done;
  logic       error;

  prog_loader #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .imem_w_en  (imem_w_en),
    .imem_addr  (imem_addr),
    .imem_w_data(imem_w_data),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  always @(posedge clock) cyc++;

  // observed strobes
  int got_a[$];
  int got_d[$];
  int last_w = -1;
  int done_rise = -1;
  int consec = 0;
  logic prev_w = 1'b0;
  logic prev_done = 1'b0;

  always @(negedge clock) begin
    if (imem_w_en === 1'b1) begin
      got_a.push_back(int'(imem_addr));
      got_d.push_back(int'(imem_w_data));
      last_w = cyc;
      if (prev_w) consec++;
    end
    prev_w = imem_w_en;
    if (done === 1'b1 && !prev_done) done_rise = cyc;
    prev_done = done;
  end

  // frames sent since the last reset, and the reference model's results
  int frame_b[$];
  bit frame_ok[$];
  int exp_a[$];
  int exp_d[$];
  int exp_done;
  int exp_err;

  // Protocol-level model: first good byte is the length (0 = 256), the next
  // N good bytes land at 0..N-1; a bad frame before completion is fatal for
  // the image, and nothing after completion matters.
  function automatic void model();
    int n = 0;
    int idx = 0;
    bit have_len = 0;
    exp_a.delete();
    exp_d.delete();
    exp_done = 0;
    exp_err = 0;
    foreach (frame_b[i]) begin
      if (exp_done || exp_err) continue;
      if (!frame_ok[i]) begin
        exp_err = 1;
      end else if (!have_len) begin
        n = (frame_b[i] == 0) ? 256 : frame_b[i];
        have_len = 1;
      end else begin
        exp_a.push_back(idx);
        exp_d.push_back(frame_b[i]);
        idx++;
        if (idx == n) exp_done = 1;
      end
    end
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clock);
    reset = 1'b1;
    rx = 1'b1;
    repeat (n) @(negedge clock);
    reset = 1'b0;
    got_a.delete();
    got_d.delete();
    frame_b.delete();
    frame_ok.delete();
    last_w = -1;
    done_rise = -1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit ok);
    frame_b.push_back(int'(b));
    frame_ok.push_back(ok);
    @(negedge clock);
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    rx = ok;
    repeat (CPB) @(negedge clock);
    if (!ok) begin
      rx = 1'b0;  // keep the line in break for a while
      repeat (8 * CPB) @(negedge clock);
    end
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clock);
  endtask

  task automatic check_writes(input string tag);
    model();
    repeat (6) @(negedge clock);
    check({tag, "_count"}, got_a.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), got_a[i], exp_a[i]);
      check($sformatf("%s_data%0d", tag, i), got_d[i], exp_d[i]);
    end
    check({tag, "_done"}, int'(done), exp_done);
    check({tag, "_cpu_reset"}, int'(cpu_reset), exp_done ? 0 : 1);
    check({tag, "_error"}, int'(error), exp_err);
  endtask

  initial begin
    int n;

    // 1: reset values and idle line
    do_reset(3);
    check("rst_cpu_reset", int'(cpu_reset), 1);
    check("rst_done", int'(done), 0);
    check("rst_error", int'(error), 0);
    check("rst_w_en", int'(imem_w_en), 0);
    check("rst_addr", int'(imem_addr), 0);
    check("rst_wdata", int'(imem_w_data), 0);
    repeat (200) @(negedge clock);
    check("idle_strobes", got_a.size(), 0);

    // 2: short image, then an extra byte that must be ignored
    send_frame(8'h03, 1'b1);
    send_frame(8'hA1, 1'b1);
    send_frame(8'hB2, 1'b1);
    send_frame(8'hC3, 1'b1);
    check_writes("short");
    check("short_done_lat", done_rise - last_w, 1);
    send_frame(8'h55, 1'b1);
    check_writes("short_extra");

    // random-length image with random contents and trailing bytes
    do_reset(2);
    n = $urandom_range(1, 12);
    send_frame(8'(n), 1'b1);
    for (int i = 0; i < n + 2; i++) send_frame(8'($urandom), 1'b1);
    check_writes("rand");
    check("rand_done_lat", done_rise - last_w, 1);

    // 3: full 256-byte image
    do_reset(2);
    send_frame(8'h00, 1'b1);
    for (int i = 0; i < 256; i++) send_frame(8'(i), 1'b1);
    check_writes("full");
    check("full_done_lat", done_rise - last_w, 1);
    send_frame(8'h00, 1'b1);
    check_writes("full_extra");

    // 4: framing error in the middle of an image
    do_reset(2);
    send_frame(8'h02, 1'b1);
    send_frame(8'h11, 1'b1);
    send_frame(8'h00, 1'b0);
    check_writes("ferr");
    send_frame(8'h22, 1'b1);
    check_writes("ferr_after");

    // 5: glitch rejection, then reset in the middle of a frame
    do_reset(2);
    @(negedge clock);
    rx = 1'b0;
    @(negedge clock);
    rx = 1'b1;
    repeat (50) @(negedge clock);
    check("glitch_strobes", got_a.size(), 0);
    check("glitch_error", int'(error), 0);
    send_frame(8'h04, 1'b1);
    send_frame(8'h10, 1'b1);
    check("midload_strobes", got_a.size(), 1);
    @(negedge clock);
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midload_cpu_reset", int'(cpu_reset), 1);
    check("midload_done", int'(done), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    got_a.delete();
    got_d.delete();
    frame_b.delete();
    frame_ok.delete();
    repeat (4 * CPB) @(negedge clock);
    send_frame(8'h01, 1'b1);
    send_frame(8'h77, 1'b1);
    check_writes("fresh");

    check("no_back_to_back", consec, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
